// File: rtl/alu_exec_stage.sv
// Execute stage behind ALUcontrol: computes result/zero/taken and holds them in a 2-entry output buffer.
// Optional feature: define ALU_OVF_EN to add the out_ovf port and its per-beat storage.
module alu_exec_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_alu_ctrl,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_taken
`ifdef ALU_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             taken;
`ifdef ALU_OVF_EN
    logic             ovf;
`endif
  } beat_t;

  // State encoding mirrors {out_valid, skid_valid}.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_e;

  function automatic beat_t alu_compute(input logic [2:0]       ctrl,
                                        input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b);
    beat_t            bt;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
`ifdef ALU_OVF_EN
    logic             is_add;
    logic             is_sub;
`endif
    bt   = '0;
    sum  = a + b;
    diff = a - b;
    case (ctrl)
      3'b010:  bt.result = sum;
      3'b110:  bt.result = diff;
      3'b000:  bt.result = a & b;
      3'b001:  bt.result = a | b;
      3'b111:  bt.result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      3'b101: begin
        bt.result = diff;
        bt.taken  = (a == b);
      end
      3'b011: begin
        bt.result = diff;
        bt.taken  = (a != b);
      end
      3'b100:  bt.result = {WIDTH{1'b0}};
      default: bt.result = {WIDTH{1'b0}};
    endcase
    bt.zero = (bt.result == {WIDTH{1'b0}});
`ifdef ALU_OVF_EN
    is_add = (ctrl == 3'b010);
    is_sub = (ctrl == 3'b110) || (ctrl == 3'b101) || (ctrl == 3'b011);
    // Overflow is judged on sign bits only: operands' signs versus the wrapped result's sign.
    bt.ovf = (is_add && (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1])) ||
             (is_sub && (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]));
`endif
    return bt;
  endfunction

  state_e state_q, state_d;
  logic   in_ready_q, in_ready_d;
  beat_t  out_q, out_d;
  beat_t  skid_q, skid_d;
  beat_t  comp_s;
  logic   in_fire_s;
  logic   out_fire_s;

  assign comp_s     = alu_compute(in_alu_ctrl, in_a, in_b);
  assign in_fire_s  = in_valid & in_ready_q;
  assign out_fire_s = (state_q != EMPTY) & out_ready;

  // Next-state and buffer-load decisions for the output/skid pair.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_fire_s) begin
          state_d = ONE;
          out_d   = comp_s;
        end else begin
          state_d = EMPTY;
        end
      end
      ONE: begin
        if (in_fire_s && out_fire_s) begin
          out_d = comp_s;
        end else if (in_fire_s) begin
          state_d = FULL;
          skid_d  = comp_s;
        end else if (out_fire_s) begin
          state_d = EMPTY;
        end else begin
          state_d = ONE;
        end
      end
      FULL: begin
        if (out_fire_s) begin
          state_d = ONE;
          out_d   = skid_q;
        end else begin
          state_d = FULL;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Registered in_ready: computed from the next state so it is valid the cycle it is needed.
    in_ready_d = (state_d != FULL);
  end

  // State, ready and data registers; reset discards both entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      out_q      <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = (state_q != EMPTY);
  assign out_result = out_q.result;
  assign out_zero   = out_q.zero;
  assign out_taken  = out_q.taken;
`ifdef ALU_OVF_EN
  assign out_ovf    = out_q.ovf;
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// Randomized bench for alu_exec_stage against a queue-based model of accepted-but-undelivered beats.
module tb_alu_exec_stage;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   in_alu_ctrl = 3'b000;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_result;
  logic         out_zero;
  logic         out_taken;
`ifdef ALU_OVF_EN
  logic         out_ovf;
`endif

  alu_exec_stage #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_alu_ctrl(in_alu_ctrl),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_taken(out_taken)
`ifdef ALU_OVF_EN
    , .out_ovf(out_ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] r;
    logic         z;
    logic         t;
    logic         o;
  } exp_t;

  exp_t q[$];
  exp_t last = '{r: '0, z: 1'b0, t: 1'b0, o: 1'b0};
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   run_chk = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference ALU from signed integer arithmetic in 64 bits.
  function automatic exp_t model(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint sa, sb, full, maxv, minv;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    maxv = (longint'(1) <<< (W - 1)) - 1;
    minv = -(longint'(1) <<< (W - 1));
    e.r = '0; e.t = 1'b0; e.o = 1'b0;
    case (c)
      3'b010: begin
        full = sa + sb;
        e.r  = W'(full);
        e.o  = (full > maxv) || (full < minv);
      end
      3'b110, 3'b101, 3'b011: begin
        full = sa - sb;
        e.r  = W'(full);
        e.o  = (full > maxv) || (full < minv);
        if (c == 3'b101) e.t = (a == b);
        else if (c == 3'b011) e.t = (a != b);
        else e.t = 1'b0;
      end
      3'b000: e.r = a & b;
      3'b001: e.r = a | b;
      3'b111: e.r = (sa < sb) ? W'(1) : W'(0);
      default: e.r = '0;
    endcase
    e.z = (e.r == '0);
    return e;
  endfunction

  // Model: push on accept, pop on delivery.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      last <= '{r: '0, z: 1'b0, t: 1'b0, o: 1'b0};
    end else begin
      if (out_valid && out_ready && q.size() > 0) last <= q.pop_front();
      if (in_valid && in_ready) q.push_back(model(in_alu_ctrl, in_a, in_b));
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin : cmp
    exp_t e;
    if (rst_n && run_chk) begin
      e = (q.size() > 0) ? q[0] : last;
      chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
      chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
      chk("out_result", 64'(out_result), 64'(e.r));
      chk("out_zero", 64'(out_zero), 64'(e.z));
      chk("out_taken", 64'(out_taken), 64'(e.t));
`ifdef ALU_OVF_EN
      chk("out_ovf", 64'(out_ovf), 64'(e.o));
`endif
    end
  end

  task automatic drive(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1; in_alu_ctrl = c; in_a = a; in_b = b;
  endtask

  // Called at a falling edge; returns at the falling edge after the beat was accepted.
  task automatic send(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    drive(c, a, b);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", n);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return W'(1);
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t m;
    logic [W-1:0] a;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_result", 64'(out_result), 64'd0);
    chk("rst_zero", 64'(out_zero), 64'd0);
    chk("rst_taken", 64'(out_taken), 64'd0);

    m = model(3'b010, 32'd5, 32'd7);
    chk("pin_add", 64'({m.r, m.z, m.t}), {30'd0, 32'd12, 2'b00});
    m = model(3'b101, 32'h1234, 32'h1234);
    chk("pin_beq", 64'({m.r, m.z, m.t}), {30'd0, 32'd0, 2'b11});
    m = model(3'b011, 32'h1234, 32'h1234);
    chk("pin_bne", 64'({m.r, m.z, m.t}), {30'd0, 32'd0, 2'b10});
    m = model(3'b111, 32'hFFFF_FFFF, 32'd1);
    chk("pin_slt", 64'(m.r), 64'd1);
    m = model(3'b010, 32'h7FFF_FFFF, 32'd1);
    chk("pin_ovf", 64'({m.r, m.o}), {31'd0, 32'h8000_0000, 1'b1});
    m = model(3'b110, 32'h8000_0000, 32'd1);
    chk("pin_sub_ovf", 64'({m.r, m.o}), {31'd0, 32'h7FFF_FFFF, 1'b1});

    @(negedge clk);
    rst_n = 1'b1;
    run_chk = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);

    send(3'b010, 32'd5, 32'd7);
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_result", 64'(out_result), 64'd12);
    chk("t1_flags", 64'({out_zero, out_taken}), 64'd0);
    send(3'b101, 32'h1234, 32'h1234);
    chk("t2_beq", 64'({out_result, out_zero, out_taken}), 64'b11);
    send(3'b011, 32'h1234, 32'h1234);
    chk("t2_bne", 64'({out_result, out_zero, out_taken}), 64'b10);
    send(3'b111, 32'hFFFF_FFFF, 32'd1);
    chk("t3_slt", 64'(out_result), 64'd1);
    send(3'b111, 32'd1, 32'hFFFF_FFFF);
    chk("t3_slt_swap", 64'({out_result, out_zero}), 64'b1);

    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    drive(3'b010, 32'd1, 32'd1);
    @(negedge clk);
    chk("t4_rdy_first", 64'(in_ready), 64'd1);
    drive(3'b010, 32'd2, 32'd2);
    @(negedge clk);
    chk("t4_rdy_low", 64'(in_ready), 64'd0);
    drive(3'b010, 32'd3, 32'd3);
    @(negedge clk);
    chk("t4_rdy_hold", 64'(in_ready), 64'd0);
    chk("t4_stable", 64'(out_result), 64'd2);
    out_ready = 1'b1;
    @(negedge clk);
    chk("t4_second", 64'(out_result), 64'd4);
    @(negedge clk);
    chk("t4_third", 64'(out_result), 64'd6);
    in_valid = 1'b0;
    @(negedge clk);
    chk("t4_drained", 64'(out_valid), 64'd0);
    chk("t4_retain", 64'(out_result), 64'd6);

    out_ready = 1'b0;
    drive(3'b010, 32'd9, 32'd9);
    @(negedge clk);
    drive(3'b110, 32'd5, 32'd3);
    @(negedge clk);
    in_valid = 1'b0;
    chk("t5_full", 64'({out_valid, in_ready}), 64'b10);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 64'(out_valid), 64'd0);
    chk("t5_rst_ready", 64'(in_ready), 64'd1);
    chk("t5_rst_result", 64'(out_result), 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;

`ifdef ALU_OVF_EN
    send(3'b010, 32'h7FFF_FFFF, 32'd1);
    chk("t6_ovf", 64'({out_result, out_ovf}), {31'd0, 32'h8000_0000, 1'b1});
    send(3'b010, 32'd1, 32'd1);
    chk("t6_no_ovf", 64'({out_result, out_ovf}), {31'd0, 32'd2, 1'b0});
`endif

    for (int i = 0; i < 3000; i++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 3) < ((i / 500) % 4 + 1)) ? 1'b1 : 1'b0;
      in_alu_ctrl = 3'($urandom_range(0, 7));
      a           = pick();
      in_a        = a;
      in_b        = ($urandom_range(0, 3) == 0) ? a : pick();
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("final_empty", 64'(out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
